// File: rtl/dsp_seq_pkg.sv
// Shared FSM encoding and DSP opmode codes for the MAC sequencer.
// No logic of its own; one helper picks the per-cycle opmode.
// Opmode bits: [0] X=M, [3] Z=P, [7] subtract.
package dsp_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] OPM_NONE  = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;
    localparam int         OPM_SUB_BIT = 7;

    function automatic logic [7:0] opm_sel(input logic acc, input logic first, input logic sub);
        logic [7:0] v;
        v = OPM_HOLD;
        if (acc) begin
            v = first ? OPM_FIRST : OPM_ACC;
            v[OPM_SUB_BIT] = sub;
        end
        return v;
    endfunction

endpackage

// File: rtl/dsp_seq_delay.sv
// Purpose: fixed-depth register delay line; DEPTH=0 degenerates to a wire.
// Latency: DEPTH cycles.
// Backpressure: none, shifts every cycle.
module dsp_seq_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_dat = i_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_dat = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Purpose: drives an external DSP slice through a len-pair dot product (MAC_SUB_EN adds negated accumulate).
// Latency: result valid LAT+OP_DLY+2 cycles after the last pair is accepted.
// Backpressure: in_ready only in RUN; result held until res_ready.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LAT    = 3,
    parameter int OP_DLY = 1,
    parameter int CNT_W  = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
`ifdef MAC_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    localparam int               DRN_W    = 8;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(LAT + OP_DLY);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DRN_W-1:0] r_dcnt;
    logic             r_first;
    logic             r_sub;
    logic [17:0]      r_a;
    logic [17:0]      r_b;
    logic [7:0]       r_op;
    logic             r_dsp_rst;
    logic             r_res_vld;
    logic [47:0]      r_res_dat;

    logic             w_sub_in;
    logic             w_start;
    logic             w_acc;
    logic [7:0]       w_op;
    logic [7:0]       w_op_dly;

`ifdef MAC_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_start = (r_state == ST_IDLE) && start && (len != '0);
    assign w_acc   = (r_state == ST_RUN) && in_valid;

    always_comb begin
        w_op = OPM_NONE;
        if (r_state == ST_RUN)
            w_op = opm_sel(w_acc, r_first, r_sub);
        else if (r_state == ST_DRAIN)
            w_op = OPM_HOLD;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dcnt    <= '0;
            r_first   <= 1'b0;
            r_sub     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OPM_NONE;
            r_dsp_rst <= 1'b0;
            r_res_vld <= 1'b0;
            r_res_dat <= '0;
        end else begin
            r_dsp_rst <= w_start;
            r_op      <= w_op;
            if (w_acc) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_state <= ST_RUN;
                    r_cnt   <= len;
                    r_first <= 1'b1;
                    r_sub   <= w_sub_in;
                end
                ST_RUN: if (w_acc) begin
                    r_first <= 1'b0;
                    // Exit at 1 rather than 0 so the counter never wraps.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DRAIN;
                        r_dcnt  <= DRN_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DRAIN: if (r_dcnt == '0) begin
                    r_state   <= ST_DONE;
                    r_res_vld <= 1'b1;
                    r_res_dat <= dsp_p;
                end else begin
                    r_dcnt <= r_dcnt - 1'b1;
                end
                ST_DONE: if (res_ready) begin
                    r_state   <= ST_IDLE;
                    r_res_vld <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Opmode trails the operands by the DSP's extra OPMODE register stage.
    dsp_seq_delay #(
        .WIDTH (8),
        .DEPTH (OP_DLY)
    ) u_op_dly (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_dat (r_op),
        .o_dat (w_op_dly)
    );

    assign busy       = (r_state != ST_IDLE);
    assign in_ready   = (r_state == ST_RUN);
    assign dsp_ce     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign dsp_rst    = r_dsp_rst;
    assign dsp_a      = r_a;
    assign dsp_b      = r_b;
    assign dsp_opmode = w_op_dly;
    assign res_valid  = r_res_vld;
    assign res_data   = r_res_dat;

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from operands presented on dsp_a/dsp_b to the result appearing on dsp_p (A1/B1 + M + P stages).
REQ-002 SHALL have parameter OP_DLY, default 1: cycles dsp_opmode lags dsp_a/dsp_b, matching the OPMODE register stage.
REQ-003 SHALL have parameter CNT_W, default 10: width of the vector-length field.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: begin a dot product of len operand pairs.
REQ-008 SHALL have port len, input, CNT_W: number of operand pairs, sampled with start.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port in_valid, input, 1, and port in_ready, output, 1: operand-pair handshake.
REQ-011 SHALL have ports in_a and in_b, input, 18 each: operand pair.
REQ-012 SHALL have ports dsp_a and dsp_b, output, 18 each: registered operands to the DSP A and B inputs.
REQ-013 SHALL have port dsp_opmode, output, 8: to the DSP OPMODE input.
REQ-014 SHALL have port dsp_ce, output, 1: common clock enable to the DSP.
REQ-015 SHALL have port dsp_rst, output, 1: active-high synchronous clear to the DSP RSTM/RSTP.
REQ-016 SHALL have port dsp_p, input, 48: DSP P output.
REQ-017 SHALL have port res_valid, output, 1, and port res_ready, input, 1: result handshake.
REQ-018 SHALL have port res_data, output, 48: accumulated result.

Function
REQ-019 SHALL implement the FSM IDLE->RUN on start with len!=0; RUN->DRAIN on the accept of the last pair; DRAIN->DONE after LAT+OP_DLY+1 cycles; DONE->IDLE on res_valid&res_ready.
REQ-020 SHALL ignore start in any state other than IDLE, and SHALL ignore start in IDLE when len==0.
REQ-021 SHALL drive in_ready=1 only in RUN; a pair is accepted on in_valid&in_ready.
REQ-022 SHALL assert dsp_rst for one cycle on the IDLE->RUN transition.
REQ-023 SHALL hold dsp_ce=1 in RUN and DRAIN, and 0 otherwise.
REQ-024 SHALL issue opmode codes per cycle in RUN: first accepted pair FIRST=0x01 (X=M, Z=0); later accepted pairs ACC=0x09 (X=M, Z=P); a cycle with no accept HOLD=0x08 (X=0, Z=P, so P is unchanged).
REQ-025 SHALL issue HOLD opmodes in DRAIN.
REQ-026 SHALL present each opmode on dsp_opmode exactly OP_DLY cycles after its operands appear on dsp_a/dsp_b.
REQ-027 SHALL, for a last pair accepted at cycle t, capture dsp_p into res_data and assert res_valid at cycle t+LAT+OP_DLY+2.
REQ-028 SHALL hold res_data stable while res_valid=1 and res_ready=0; res_valid=1 SHALL persist until the handshake completes.
REQ-029 SHALL keep the length counter from wrapping: it counts down from len and RUN exits at 1.
REQ-030 SHALL treat the accumulation as 48-bit two's complement; overflow SHALL wrap without flagging.

Reset
REQ-031 SHALL, on RST_N low, asynchronously set the state to IDLE and clear the counters, busy, in_ready, res_valid, res_data, dsp_a, dsp_b, dsp_ce and dsp_rst to 0, and dsp_opmode to 0x00.
REQ-032 SHALL, on reset mid-operation, abandon any partial result and emit no res_valid afterwards.

Configuration
REQ-033 SHALL, with MAC_SUB_EN defined, provide an input sub (1 bit, sampled with start) that sets opmode bit 7 on FIRST and ACC, giving P = -sum(a*b).
REQ-034 SHALL, without MAC_SUB_EN, have no sub port and keep opmode bit 7 at 0.

Structure
REQ-035 SHALL place the FSM state encoding and the FIRST/ACC/HOLD opmode constants in the shared package dsp_seq_pkg.
REQ-036 SHALL implement the OP_DLY opmode delay line as sub-module dsp_seq_delay (parameters WIDTH, DEPTH; DEPTH=0 is a wire).

Verification
REQ-037 SHALL cover: len=4, a=1,2,3,4, b=2, back-to-back -> res_data=20, res_valid at last accept+6 with default parameters.
REQ-038 SHALL cover: len=3, a=b=-5 with two idle cycles inserted -> res_data=75, HOLD (0x08) issued during the idle cycles.
REQ-039 SHALL cover: res_ready held 0 for 10 cycles -> res_valid and res_data stable; a start pulse during that window is ignored.
REQ-040 SHALL cover: RST_N pulsed low mid-RUN -> all outputs 0 immediately; a following len=1, a=7, b=3 gives 21.
REQ-041 SHALL cover: start with len=0 -> busy stays 0 and no dsp_ce activity.
REQ-042 SHALL cover, with MAC_SUB_EN: sub=1, len=2, a=3, b=4 -> res_data=-24 (0xFFFF_FFFF_FFE8).
